// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage plus architectural register file. This is the consumer end
//   of the MEM/WB pipeline register. It selects the writeback value (ALU result
//   or load data), commits it to a 2^ADDR_W x DATA_W register file, serves the
//   two ID-stage read ports, exports the writeback value for the forwarding
//   unit, and keeps a retired-write counter for debug.
//
//   Register 0 is hardwired to zero. It is never written, and it reads as zero
//   on every port.
//
// Configuration macro
//   WB_BYPASS_EN  When defined, a read port that addresses the register being
//                 written this cycle returns wbValue in the same cycle
//                 (write-through).
//                 When undefined, the read port returns the stored value until
//                 after the commit edge, and the hazard unit must stall one
//                 extra cycle. dbgData never uses the bypass.
//
// Parameters
//   DATA_W  register / datapath width
//   ADDR_W  register index width (2^ADDR_W registers)
//   CNT_W   width of the retired-write counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   regWrite   MEM/WB commit enable
//   memToReg   MEM/WB writeback select (1 = data, 0 = res)
//   res        MEM/WB ALU result
//   data       MEM/WB load data
//   dest       MEM/WB destination register index
//   rdAddr1/2  ID read port indices
//   rdData1/2  ID read port data (combinational)
//   wbValue    muxed writeback value to the forwarding unit (combinational)
//   wbValid    regWrite && dest != 0 (combinational)
//   dbgAddr    debug read index
//   dbgData    debug read data (stored value only, never bypassed)
//   retireCnt  count of committed writes (registered, wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic [DATA_W-1:0] res,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] dest,
  input  logic [ADDR_W-1:0] rdAddr1,
  input  logic [ADDR_W-1:0] rdAddr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic [DATA_W-1:0] wbValue,
  output logic              wbValid,
  input  logic [ADDR_W-1:0] dbgAddr,
  output logic [DATA_W-1:0] dbgData,
  output logic [CNT_W-1:0]  retireCnt
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Writeback select and commit qualifier
  // ---------------------------------------------------------------------------
  assign wbValue = memToReg ? data : res;
  // A write to r0 is a legal encoding. It must neither store nor count.
  assign wbValid = regWrite && (dest != '0);

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  // NOTE: the whole array has an async clear, so it maps to flops, not to a
  // RAM macro. Architectural state must read zero immediately on reset,
  // without waiting for a clock edge.
  // NOTE: sequential state uses non-blocking (<=) assignments only. This way,
  // every reader in the same edge sees the pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wbValid) begin
      regs[dest] <= wbValue;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-write counter. It wraps naturally at 2^CNT_W.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retireCnt <= '0;
    end else if (wbValid) begin
      retireCnt <= retireCnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Asynchronous read ports
  // ---------------------------------------------------------------------------
  // NOTE: every output of this always_comb gets a default first. Because of
  // that, no path through the block can leave a value held, and no latch is
  // inferred.
  always_comb begin
    rdData1 = '0;
    rdData2 = '0;
    dbgData = '0;

    if (rdAddr1 != '0) rdData1 = regs[rdAddr1];
    if (rdAddr2 != '0) rdData2 = regs[rdAddr2];
    if (dbgAddr != '0) dbgData = regs[dbgAddr];

`ifdef WB_BYPASS_EN
    // wbValid already excludes dest == 0, so r0 stays zero. Gating with rst
    // keeps the read ports at zero while reset is held, even if MEM/WB still
    // presents a write.
    if (rst && wbValid && (rdAddr1 == dest)) rdData1 = wbValue;
    if (rst && wbValid && (rdAddr2 == dest)) rdData2 = wbValue;
`endif
  end

endmodule
